inst_sram_resp: RTL and testbench
=================================

INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning log2 of the memory depth in 32-bit words (4096 words).
REQ-002 SHALL have parameter BASE, default 32'h1c000000, meaning the byte address of word 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port sram_en, input, 1, access request this cycle.
REQ-006 SHALL have port sram_we, input, 4, byte write enables; 4'b0 means read.
REQ-007 SHALL have port sram_addr, input, 32, byte address.
REQ-008 SHALL have port sram_wdata, input, 32, write data, byte lane i = bits [8i+7:8i].
REQ-009 SHALL have port sram_rdata, output, 32, read data for the previous accepted access.
REQ-010 SHALL have port addr_err, output, 1, one-cycle flag aligned with the sram_rdata of a rejected access.
REQ-011 SHALL have port rd_cnt, output, 32, count of accepted reads.
REQ-012 SHALL have port wr_cnt, output, 32, count of accepted writes.

Function
REQ-013 SHALL compute the word index as (sram_addr - BASE) >> 2, taking the low ADDR_W bits.
REQ-014 SHALL reject an access when sram_addr[1:0] != 0, sram_addr < BASE, or sram_addr >= BASE + 4*2^ADDR_W; all other accesses are accepted.
REQ-015 SHALL, on an accepted read (en=1, we=0) at edge N, present mem[index] on sram_rdata after edge N (1-cycle latency).
REQ-016 SHALL, on an accepted write (en=1, we!=0), update only the bytes whose we bit is 1, at the same edge.
REQ-017 SHALL, on an accepted write, load sram_rdata with the word as it was before the write (read-first), unless REQ-027 applies.
REQ-018 SHALL hold sram_rdata and drive addr_err to 0 in every cycle following one with sram_en=0; a stalled fetcher re-samples the same instruction indefinitely.
REQ-019 SHALL, on a rejected access, perform no memory write, load sram_rdata with 32'h0, and set addr_err to 1 for exactly the following cycle.
REQ-020 SHALL drive addr_err to 0 after any accepted access.
REQ-021 SHALL increment rd_cnt by 1 per accepted read and wr_cnt by 1 per accepted write, wrapping from 32'hffffffff to 0; rejected and idle cycles do not count.
REQ-022 SHALL make back-to-back accesses at consecutive edges independent; a read one cycle after a write to the same word returns the updated word.

Reset
REQ-023 SHALL, at any edge with resetn=0, set sram_rdata=0, addr_err=0, rd_cnt=0, and wr_cnt=0.
REQ-024 SHALL, at any edge with resetn=0, ignore sram_en entirely: no memory write and no counting, even mid-sequence.
REQ-025 SHALL leave memory contents unchanged by reset; the array is not initialised by hardware.
REQ-026 SHALL treat the first edge with resetn=1 as a normal access cycle.

Configuration
REQ-027 SHALL, when macro INST_SRAM_WRITE_FIRST_EN is defined, make an accepted write load sram_rdata with the merged new word (write-first); without the macro, read-first per REQ-017 applies; all other behaviour is identical in both builds.

Verification
REQ-028 SHALL cover this scenario: write 32'h11223344 at 0x1c000000 with we=4'hf, then read the same address -> sram_rdata=32'h11223344 one cycle after the read, and rd_cnt=1, wr_cnt=1.
REQ-029 SHALL cover this scenario: with the word holding 32'h11223344, write 32'hAABBCCDD with we=4'b0101 -> next-cycle sram_rdata is 32'h11223344 (default) or 32'h11BB33DD (INST_SRAM_WRITE_FIRST_EN); a following read returns 32'h11BB33DD.
REQ-030 SHALL cover this scenario: read 0x1c000004 holding 32'h02800000, then hold sram_en=0 for 5 cycles -> sram_rdata stays 32'h02800000, addr_err=0, and rd_cnt is unchanged.
REQ-031 SHALL cover this scenario: read 0x1bfffffc, 0x1c000002, and 0x1c004000 (ADDR_W=12) -> each gives sram_rdata=0 with a one-cycle addr_err pulse, no memory change, and rd_cnt unchanged.
REQ-032 SHALL cover this scenario: assert resetn=0 for one cycle during a write stream -> the write at that edge is not performed, outputs are 0, previously written words survive, and the next read returns them.
REQ-033 SHALL cover this scenario: force rd_cnt to 32'hffffffff via 2^32 reads, or a backdoor preload in simulation, then issue one read -> rd_cnt=0.

Source files
------------

// File: rtl/inst_sram_resp.sv
// inst_sram_resp: single-port instruction SRAM with a one-cycle registered
// response, address range checking and read/write access counters.
// Optional build macro INST_SRAM_WRITE_FIRST_EN: an accepted write returns the
// merged new word instead of the pre-write word.
module inst_sram_resp #(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        addr_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       off;
  logic              in_rng;
  logic              accept;
  logic              is_wr;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       old_word;
  logic [31:0]       merged;

  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;

  // Offset from BASE; anything below BASE or past the last word is rejected.
  // Checking the offset's high bits avoids overflow in BASE + 4*DEPTH.
  assign off      = sram_addr - BASE;
  assign in_rng   = (sram_addr >= BASE) && ((off >> (ADDR_W + 2)) == 32'd0);
  assign accept   = sram_en && (sram_addr[1:0] == 2'b00) && in_rng;
  assign is_wr    = |sram_we;
  assign idx      = off[ADDR_W+1:2];
  assign old_word = mem[idx];

  // Byte-lane merge of the write data into the current word.
  always_comb begin
    merged = old_word;
    for (int b = 0; b < 4; b++)
      if (sram_we[b]) merged[8*b +: 8] = sram_wdata[8*b +: 8];
  end

  // Response and counter next-state; idle cycles hold the last response.
  always_comb begin
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (sram_en) begin
      if (accept) begin
        if (is_wr) begin
`ifdef INST_SRAM_WRITE_FIRST_EN
          rdata_d = merged;
`else
          rdata_d = old_word;
`endif
          wr_cnt_d = wr_cnt_q + 32'd1;
        end else begin
          rdata_d  = old_word;
          rd_cnt_d = rd_cnt_q + 32'd1;
        end
      end else begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
      end
    end
  end

  // Response/counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage array: never cleared, and writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (resetn && accept && is_wr) mem[idx] <= merged;
  end

  assign sram_rdata = rdata_q;
  assign addr_err   = err_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Scoreboard bench for inst_sram_resp: the driver computes the expected
// response of every cycle from a word-array model and queues it; a monitor
// pops and compares after each rising edge.
module tb_inst_sram_resp;
  localparam int          ADDR_W = 12;
  localparam logic [31:0] BASE   = 32'h1c000000;
  localparam longint      DEPTH  = longint'(1) << ADDR_W;

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        addr_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  inst_sram_resp #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .addr_err(addr_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] rd;
    logic [31:0] wr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [int];
  logic [31:0] m_rdata = 32'h0;
  logic        m_err   = 1'b0;
  logic [31:0] m_rd    = 32'h0;
  logic [31:0] m_wr    = 32'h0;
  int          n_cmp   = 0;
  int          n_bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Apply one cycle of stimulus and queue the response it must produce.
  task automatic cyc(input logic rstn, input logic en, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] wdata);
    longint      a;
    int          wi;
    logic [31:0] old, nw;
    resetn = rstn; sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wdata;
    a = longint'(addr);
    if (!rstn) begin
      m_rdata = 32'h0; m_err = 1'b0; m_rd = 32'h0; m_wr = 32'h0;
    end else if (!en) begin
      m_err = 1'b0;
    end else if ((a % 4) == 0 && a >= longint'(BASE) && a < longint'(BASE) + 4 * DEPTH) begin
      wi    = int'((a - longint'(BASE)) / 4);
      old   = mem_m.exists(wi) ? mem_m[wi] : 32'hx;
      m_err = 1'b0;
      if (we == 4'h0) begin
        m_rdata = old;
        m_rd    = m_rd + 32'd1;
      end else begin
        nw = old;
        for (int b = 0; b < 4; b++)
          if (we[b]) nw[8*b +: 8] = wdata[8*b +: 8];
        mem_m[wi] = nw;
        m_wr      = m_wr + 32'd1;
`ifdef INST_SRAM_WRITE_FIRST_EN
        m_rdata = nw;
`else
        m_rdata = old;
`endif
      end
    end else begin
      m_rdata = 32'h0;
      m_err   = 1'b1;
    end
    sb.push_back('{rdata: m_rdata, err: m_err, rd: m_rd, wr: m_wr});
    @(negedge clk);
  endtask

  // Monitor: one response per cycle, checked just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sram_rdata", sram_rdata, e.rdata);
        chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
        chk("rd_cnt", rd_cnt, e.rd);
        chk("wr_cnt", wr_cnt, e.wr);
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    case ($urandom_range(9))
      0:       r = BASE - 32'(4 * $urandom_range(1, 4));
      1:       r = BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      2:       r = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      3:       r = BASE + 32'(4 * (DEPTH - 1));
      default: r = BASE + 32'(4 * $urandom_range(0, 15));
    endcase
    return r;
  endfunction

  initial begin
    logic [3:0] we;
    // Reset with a request pending: nothing happens.
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 4'hf, BASE, 32'hdeadbeef);

    // Full write then read back.
    cyc(1'b1, 1'b1, 4'hf, BASE, 32'h11223344);
    cyc(1'b1, 1'b1, 4'h0, BASE, 32'h0);

    // Partial byte write, then read of the merged word.
    cyc(1'b1, 1'b1, 4'b0101, BASE, 32'hAABBCCDD);
    cyc(1'b1, 1'b1, 4'h0, BASE, 32'h0);

    // Read followed by a stall: response and counters hold.
    cyc(1'b1, 1'b1, 4'hf, BASE + 32'd4, 32'h02800000);
    cyc(1'b1, 1'b1, 4'h0, BASE + 32'd4, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

    // Rejected reads and a rejected write that would alias word 0.
    cyc(1'b1, 1'b1, 4'h0, 32'h1bfffffc, 32'h0);
    cyc(1'b1, 1'b1, 4'h0, 32'h1c000002, 32'h0);
    cyc(1'b1, 1'b1, 4'h0, 32'h1c004000, 32'h0);
    cyc(1'b1, 1'b1, 4'hf, 32'h1c004000, 32'hdeadbeef);
    cyc(1'b1, 1'b1, 4'h0, BASE, 32'h0);

    // Reset in the middle of a write stream.
    cyc(1'b1, 1'b1, 4'hf, BASE + 32'd8,  32'h22222222);
    cyc(1'b1, 1'b1, 4'hf, BASE + 32'd12, 32'h33333333);
    cyc(1'b1, 1'b1, 4'hf, BASE + 32'd16, 32'h44444444);
    cyc(1'b0, 1'b1, 4'hf, BASE + 32'd16, 32'h0badf00d);
    cyc(1'b1, 1'b1, 4'h0, BASE + 32'd16, 32'h0);
    cyc(1'b1, 1'b1, 4'h0, BASE + 32'd8,  32'h0);
    cyc(1'b1, 1'b1, 4'h0, BASE + 32'd12, 32'h0);

    // Read counter wrap via backdoor preload.
    force dut.rd_cnt_q = 32'hffffffff;
    #1;
    release dut.rd_cnt_q;
    m_rd = 32'hffffffff;
    cyc(1'b1, 1'b1, 4'h0, BASE + 32'd4, 32'h0);
    cyc(1'b1, 1'b1, 4'h0, BASE, 32'h0);

    // Preload every word the random phase can read, then random traffic.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 4'hf, BASE + 32'(4 * i), $urandom);
    cyc(1'b1, 1'b1, 4'hf, BASE + 32'(4 * (DEPTH - 1)), $urandom);
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      cyc(($urandom_range(49) != 0), ($urandom_range(9) < 7), we, rand_addr(), $urandom);
    end
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
